axis_step_scheduler: RTL

//  Schedules step moves for the four machine axes: x, y, z and e (extruder).

---
 rtl/axis_step_scheduler.sv | 121 ++++++++++++
 1 files changed

// File: rtl/axis_step_scheduler.sv
// Four-axis step scheduler: per-axis move commands, one shared step tick
// arbitrated round-robin, Gray-code phase outputs packed onto an 8-bit bus.
module axis_step_scheduler #(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_axis,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    output logic [7:0]       phase,
    output logic [3:0]       busy,
    output logic             idle,
    output logic             step_valid,
    output logic [1:0]       step_axis
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] pending_q [4];
    logic [CNT_W-1:0] pending_d [4];
    logic [3:0]       dir_q, dir_d;
    logic [7:0]       phase_q, phase_d;
    logic [1:0]       rr_last_q, rr_last_d;
    logic             step_valid_q, step_valid_d;
    logic [1:0]       step_axis_q, step_axis_d;

    logic             tick;
    logic             accept;
    logic             win_found;
    logic [1:0]       win_axis;
    logic [1:0]       cand;
    logic [3:0]       busy_vec;

    // One Gray step: forward 00->01->11->10, reverse is the inverse walk.
    function automatic logic [1:0] gray_step(input logic [1:0] g, input logic fwd);
        return fwd ? {g[0], ~g[1]} : {~g[0], g[1]};
    endfunction

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            busy_vec[n] = (pending_q[n] != '0);
        end
    end

    assign cmd_ready  = (pending_q[cmd_axis] == '0);
    assign busy       = busy_vec;
    assign idle       = (busy_vec == 4'b0000);
    assign phase      = phase_q;
    assign step_valid = step_valid_q;
    assign step_axis  = step_axis_q;

    always_comb begin
        presc_d      = presc_q;
        pending_d    = pending_q;
        dir_d        = dir_q;
        phase_d      = phase_q;
        rr_last_d    = rr_last_q;
        step_valid_d = 1'b0;
        step_axis_d  = step_axis_q;
        win_found    = 1'b0;
        win_axis     = 2'd0;
        cand         = 2'd0;

        tick    = (presc_q == TICK_LAST);
        presc_d = tick ? '0 : presc_q + PW'(1);
        accept  = cmd_valid && cmd_ready;

        // Round-robin search starting after the last winner; pre-edge counts only.
        for (int i = 1; i <= 4; i++) begin
            cand = rr_last_q + 2'(i);
            if (!win_found && (pending_q[cand] != '0)) begin
                win_found = 1'b1;
                win_axis  = cand;
            end
        end

        if (accept) begin
            pending_d[cmd_axis] = cmd_steps;
            dir_d[cmd_axis]     = cmd_dir;
        end

        // A just-accepted axis had pending==0 pre-edge, so it can never be the winner here.
        if (tick && win_found) begin
            pending_d[win_axis]             = pending_q[win_axis] - CNT_W'(1);
            phase_d[{win_axis, 1'b0} +: 2]  = gray_step(phase_q[{win_axis, 1'b0} +: 2],
                                                        dir_q[win_axis]);
            rr_last_d                       = win_axis;
            step_valid_d                    = 1'b1;
            step_axis_d                     = win_axis;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q      <= '0;
            for (int n = 0; n < 4; n++) begin
                pending_q[n] <= '0;
            end
            dir_q        <= 4'b0000;
            phase_q      <= 8'h00;
            rr_last_q    <= 2'd3;
            step_valid_q <= 1'b0;
            step_axis_q  <= 2'd0;
        end else begin
            presc_q      <= presc_d;
            pending_q    <= pending_d;
            dir_q        <= dir_d;
            phase_q      <= phase_d;
            rr_last_q    <= rr_last_d;
            step_valid_q <= step_valid_d;
            step_axis_q  <= step_axis_d;
        end
    end

endmodule
